exposure_sequencer: RTL and testbench

Frame-level scheduler on the ADC_PIXCLK domain. It sequences pixel global reset, modulated exposure sub-frames and hand-off to the row readout FSM through the FSMIND0/FSMIND0ACK and FSMIND1/FSMIND1ACK handshake pair. It acts as the "other state machine" partner of the readout timing generator. It guarantees that exposure and readout never overlap, and it runs single, counted or continuous frame sequences under host control.

---
 rtl/exposure_sequencer_pkg.sv | 28 ++
 rtl/exposure_sequencer_if.sv | 38 +++
 rtl/exposure_sequencer_exp_down_counter.sv | 26 ++
 rtl/exposure_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_exposure_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exposure_sequencer_pkg.sv
// Shared types and helpers for the exposure sequencer: the FSM state encoding, index/frame
// widths, and the zero-to-one and clamp fixups applied to the host configuration.
package exposure_seq_pkg;

  localparam int unsigned SUB_IDX_W = 3;
  localparam int unsigned FRAME_W   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRo,
    StGrst,
    StExpose,
    StGap,
    StHandoff,
    StNext
  } seq_state_e;

  function automatic logic [31:0] zero_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  function automatic logic [3:0] clamp_num_sub(input logic [3:0] n, input int unsigned max_sub);
    if (n == 4'd0) return 4'd1;
    if (32'(n) > max_sub) return 4'(max_sub);
    return n;
  endfunction

endpackage

// File: rtl/exposure_sequencer_if.sv
// Host and readout-FSM handshake bundle of the exposure sequencer.
// master: the sequencer itself; slave: the host / readout timing generator side.
interface exposure_sequencer_if
  import exposure_seq_pkg::*;
#(
  parameter int unsigned C_EXP_W = 16
);
  logic                 START;
  logic                 STOP;
  logic                 CONTINUOUS;
  logic [FRAME_W-1:0]   NUM_FRAMES;
  logic [C_EXP_W-1:0]   EXP_CYC;
  logic [3:0]           NUM_SUB;
  logic                 FSMIND0;
  logic                 FSMIND1ACK;
  logic                 FSMIND0ACK;
  logic                 FSMIND1;
  logic                 GRST;
  logic                 MOD_EN;
  logic                 SUB_STROBE;
  logic [SUB_IDX_W-1:0] SUB_IDX;
  logic [FRAME_W-1:0]   FRAME_CNT;
  logic                 FRAME_DONE;
  logic                 BUSY;
  logic                 ERR;

  modport master (
    input  START, STOP, CONTINUOUS, NUM_FRAMES, EXP_CYC, NUM_SUB, FSMIND0, FSMIND1ACK,
    output FSMIND0ACK, FSMIND1, GRST, MOD_EN, SUB_STROBE, SUB_IDX, FRAME_CNT, FRAME_DONE,
           BUSY, ERR
  );

  modport slave (
    output START, STOP, CONTINUOUS, NUM_FRAMES, EXP_CYC, NUM_SUB, FSMIND0, FSMIND1ACK,
    input  FSMIND0ACK, FSMIND1, GRST, MOD_EN, SUB_STROBE, SUB_IDX, FRAME_CNT, FRAME_DONE,
           BUSY, ERR
  );
endinterface

// File: rtl/exposure_sequencer_exp_down_counter.sv
// Loadable down-counter shared by the GRST, EXPOSE, GAP and hand-off timeout phases.
// tc flags the last cycle of a loaded interval; the count parks at zero when idle.
module exp_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/exposure_sequencer.sv
// Frame scheduler: global reset, modulated exposure sub-frames, then hand-off to readout.
// Define SEQ_ACK_TIMEOUT_EN to bound the FSMIND1ACK wait and enable the sticky ERR flag.
module exposure_sequencer
  import exposure_seq_pkg::*;
#(
  parameter int unsigned C_EXP_W       = 16,
  parameter int unsigned C_NUM_SUB_MAX = 8,
  parameter int unsigned C_GRST_CYC    = 12,
  parameter int unsigned C_SUB_GAP     = 2,
  parameter int unsigned C_TIMEOUT     = 65535
) (
  input logic                   ADC_PIXCLK,
  input logic                   RESETN,
  exposure_sequencer_if.master  bus
);
  localparam int unsigned TmoW  = $clog2(C_TIMEOUT + 1);
  localparam int unsigned GrstW = $clog2(C_GRST_CYC + 1);
  localparam int unsigned MaxW  = (C_EXP_W > TmoW) ? C_EXP_W : TmoW;
  localparam int unsigned CntW  = (MaxW > GrstW) ? MaxW : GrstW;

  seq_state_e           state_q;
  logic [FRAME_W-1:0]   num_frames_q, frame_cnt_q;
  logic [3:0]           num_sub_q;
  logic [C_EXP_W-1:0]   exp_q;
  logic [SUB_IDX_W-1:0] sub_idx_q;
  logic                 cont_q, stop_pend_q;
  logic                 ack_q, f1_q, grst_q, mod_q, strobe_q, done_q, busy_q;
  logic                 cnt_load, cnt_tc, last_sub;
  logic [CntW-1:0]      cnt_val;

  assign last_sub = ({1'b0, sub_idx_q} == (num_sub_q - 4'd1));

  // One counter serves every timed phase; each phase loads the next one on its last cycle.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      StWaitRo: if (ack_q) begin
        cnt_load = 1'b1;
        cnt_val  = CntW'(C_GRST_CYC);
      end
      StGrst, StGap: if (cnt_tc) begin
        cnt_load = 1'b1;
        cnt_val  = CntW'(exp_q);
      end
      StExpose: if (cnt_tc) begin
        cnt_load = 1'b1;
        cnt_val  = last_sub ? CntW'(C_TIMEOUT) : CntW'(C_SUB_GAP);
      end
      default: ;
    endcase
  end

  exp_down_counter #(
    .W (CntW)
  ) u_cnt (
    .clk      (ADC_PIXCLK),
    .rst_n    (RESETN),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

`ifdef SEQ_ACK_TIMEOUT_EN
  logic err_q;
`endif

  always_ff @(posedge ADC_PIXCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= StIdle;
      num_frames_q <= '0;
      frame_cnt_q  <= '0;
      num_sub_q    <= '0;
      exp_q        <= '0;
      sub_idx_q    <= '0;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      ack_q        <= 1'b0;
      f1_q         <= 1'b0;
      grst_q       <= 1'b0;
      mod_q        <= 1'b0;
      strobe_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      ack_q    <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      if (state_q != StIdle && bus.STOP) stop_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: if (bus.START) begin
          num_frames_q <= FRAME_W'(zero_to_one(32'(bus.NUM_FRAMES)));
          num_sub_q    <= clamp_num_sub(bus.NUM_SUB, C_NUM_SUB_MAX);
          cont_q       <= bus.CONTINUOUS;
          frame_cnt_q  <= '0;
          stop_pend_q  <= bus.STOP;  // START+STOP together yields a single frame
          busy_q       <= 1'b1;
`ifdef SEQ_ACK_TIMEOUT_EN
          err_q        <= 1'b0;
`endif
          state_q      <= StWaitRo;
        end
        StWaitRo: begin
          if (ack_q) begin
            grst_q    <= 1'b1;
            exp_q     <= C_EXP_W'(zero_to_one(32'(bus.EXP_CYC)));
            sub_idx_q <= '0;
            state_q   <= StGrst;
          end else if (bus.FSMIND0) begin
            ack_q <= 1'b1;
          end
        end
        StGrst: if (cnt_tc) begin
          grst_q   <= 1'b0;
          mod_q    <= 1'b1;
          strobe_q <= 1'b1;
          state_q  <= StExpose;
        end
        StExpose: if (cnt_tc) begin
          mod_q <= 1'b0;
          if (last_sub) begin
            f1_q    <= 1'b1;
            state_q <= StHandoff;
          end else begin
            sub_idx_q <= sub_idx_q + 1'b1;
            state_q   <= StGap;
          end
        end
        StGap: if (cnt_tc) begin
          mod_q    <= 1'b1;
          strobe_q <= 1'b1;
          state_q  <= StExpose;
        end
        StHandoff: begin
          if (bus.FSMIND1ACK) begin
            f1_q    <= 1'b0;
            done_q  <= 1'b1;
            if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
            state_q <= StNext;
          end
`ifdef SEQ_ACK_TIMEOUT_EN
          else if (cnt_tc) begin
            f1_q    <= 1'b0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
`endif
        end
        StNext: begin
          if (stop_pend_q || (!cont_q && frame_cnt_q == num_frames_q)) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            state_q <= StWaitRo;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.FSMIND0ACK = ack_q;
  assign bus.FSMIND1    = f1_q;
  assign bus.GRST       = grst_q;
  assign bus.MOD_EN     = mod_q;
  assign bus.SUB_STROBE = strobe_q;
  assign bus.SUB_IDX    = sub_idx_q;
  assign bus.FRAME_CNT  = frame_cnt_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.BUSY       = busy_q;
`ifdef SEQ_ACK_TIMEOUT_EN
  assign bus.ERR        = err_q;
`else
  assign bus.ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_exposure_sequencer.sv
// Bench for exposure_sequencer: expected output events are queued per stimulus and
// compared in order against events captured from the DUT pins.
module tb_exposure_sequencer;
  localparam int C_GRST = 12;
  localparam int C_GAP  = 2;
  localparam int EV_NONE = 0, EV_ACK = 1, EV_GRST = 2, EV_STROBE = 3, EV_MOD = 4, EV_F1 = 5,
                 EV_DONE = 6, EV_BAD = 7;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] val;
  } ev_t;

  logic ADC_PIXCLK = 1'b0;
  logic RESETN;
  int   n_vec = 0;
  int   n_miss = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  bit   ack_en = 1'b1;
  int   ack_dly = 0;
  int   f1_wait = 0;
  int   grst_run = 0, mod_run = 0, f1_run = 0;

  always #5 ADC_PIXCLK = ~ADC_PIXCLK;

  exposure_sequencer_if #(.C_EXP_W(16)) bus ();

  exposure_sequencer #(
    .C_EXP_W       (16),
    .C_NUM_SUB_MAX (8),
    .C_GRST_CYC    (12),
    .C_SUB_GAP     (2),
    .C_TIMEOUT     (20)
  ) dut (
    .ADC_PIXCLK (ADC_PIXCLK),
    .RESETN     (RESETN),
    .bus        (bus)
  );

  function automatic ev_t ev(input int k, input int v);
    ev_t r;
    r.kind = 4'(k);
    r.val  = 32'(v);
    return r;
  endfunction

  // Expected event stream of one frame; cnt==0 means the hand-off times out (no FRAME_DONE).
  function automatic void push_frame(input int ns, input int e, input int dly, input int cnt);
    exp_q.push_back(ev(EV_ACK, 0));
    exp_q.push_back(ev(EV_GRST, C_GRST));
    for (int s = 0; s < ns; s++) begin
      exp_q.push_back(ev(EV_STROBE, s));
      exp_q.push_back(ev(EV_MOD, e));
    end
    exp_q.push_back(ev(EV_F1, dly + 1));
    if (cnt != 0) exp_q.push_back(ev(EV_DONE, cnt));
  endfunction

  // Readout partner: acknowledge FSMIND1 ack_dly cycles after it is first seen.
  always @(negedge ADC_PIXCLK) begin
    bus.FSMIND1ACK = 1'b0;
    if (ack_en && bus.FSMIND1) begin
      if (f1_wait == ack_dly) begin
        bus.FSMIND1ACK = 1'b1;
        f1_wait = 0;
      end else begin
        f1_wait++;
      end
    end else begin
      f1_wait = 0;
    end
  end

  // Event capture: pulse events and run lengths of GRST, MOD_EN and FSMIND1.
  always @(negedge ADC_PIXCLK) begin
    if (!RESETN) begin
      grst_run = 0;
      mod_run  = 0;
      f1_run   = 0;
    end else begin
      if (bus.FSMIND0ACK) obs_q.push_back(ev(EV_ACK, 0));
      if (bus.GRST) grst_run++;
      else if (grst_run != 0) begin obs_q.push_back(ev(EV_GRST, grst_run)); grst_run = 0; end
      if (bus.SUB_STROBE) obs_q.push_back(ev(EV_STROBE, int'(bus.SUB_IDX)));
      if (bus.MOD_EN) mod_run++;
      else if (mod_run != 0) begin obs_q.push_back(ev(EV_MOD, mod_run)); mod_run = 0; end
      if (bus.FSMIND1) f1_run++;
      else if (f1_run != 0) begin obs_q.push_back(ev(EV_F1, f1_run)); f1_run = 0; end
      if (bus.FRAME_DONE) obs_q.push_back(ev(EV_DONE, int'(bus.FRAME_CNT)));
      if ((bus.GRST && bus.MOD_EN) || (bus.FSMIND1 && (bus.GRST || bus.MOD_EN)))
        obs_q.push_back(ev(EV_BAD, 0));
    end
  end

  task automatic set_cfg(input int nf, input int ns, input int e, input bit cont);
    bus.NUM_FRAMES = 16'(nf);
    bus.NUM_SUB    = 4'(ns);
    bus.EXP_CYC    = 16'(e);
    bus.CONTINUOUS = cont;
  endtask

  task automatic pulse_start();
    @(negedge ADC_PIXCLK) bus.START = 1'b1;
    @(negedge ADC_PIXCLK) bus.START = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (bus.BUSY && k < 3000) begin @(negedge ADC_PIXCLK); k++; end
    n_vec++;
    if (bus.BUSY) begin n_miss++; $display("FAIL %s_idle: BUSY still %b, want 0", name, bus.BUSY); end
    repeat (3) @(negedge ADC_PIXCLK);
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    bus.START = 1'b0; bus.STOP = 1'b0; bus.FSMIND0 = 1'b0;
    set_cfg(1, 1, 1, 1'b0);
    repeat (3) @(negedge ADC_PIXCLK);
    n_vec++;
    if ({bus.FSMIND0ACK, bus.FSMIND1, bus.GRST, bus.MOD_EN, bus.SUB_STROBE, bus.FRAME_DONE,
         bus.BUSY, bus.ERR, bus.SUB_IDX, bus.FRAME_CNT} !== 27'd0) begin
      n_miss++; $display("FAIL reset_outs: got nonzero outputs, want all 0");
    end
    RESETN = 1'b1;
    repeat (4) @(negedge ADC_PIXCLK);
    n_vec++;
    if ({bus.BUSY, bus.FSMIND0ACK, bus.GRST} !== 3'b000) begin
      n_miss++; $display("FAIL reset_idle: got %b, want 000", {bus.BUSY, bus.FSMIND0ACK, bus.GRST});
    end
  endtask

  task automatic test_single();
    ev_t e, o;
    logic [2:0] want [3] = '{3'b100, 3'b110, 3'b101};
    bus.FSMIND0 = 1'b1;
    ack_dly = 7;
    set_cfg(1, 1, 5, 1'b0);
    push_frame(1, 5, 7, 1);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({bus.BUSY, bus.FSMIND0ACK, bus.GRST} !== want[i]) begin
        n_miss++;
        $display("FAIL single_lat%0d: {BUSY,ACK0,GRST} got %b, want %b", i,
                 {bus.BUSY, bus.FSMIND0ACK, bus.GRST}, want[i]);
      end
      @(negedge ADC_PIXCLK);
    end
    wait_idle("single");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev(EV_NONE, 0);
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL single_evt: got kind=%0d val=%0d, want kind=%0d val=%0d",
                 o.kind, o.val, e.kind, e.val);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_miss++; $display("FAIL single_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
    n_vec++;
    if (bus.FRAME_CNT !== 16'd1) begin
      n_miss++; $display("FAIL single_cnt: FRAME_CNT got %0d, want 1", bus.FRAME_CNT);
    end
  endtask

  task automatic test_multi_sub();
    ev_t e, o;
    int k = 0, n = 0;
    int want_len = C_GRST + 3 * 4 + 2 * C_GAP;
    ack_dly = 2;
    set_cfg(1, 3, 4, 1'b0);
    push_frame(3, 4, 2, 1);
    pulse_start();
    while (!bus.GRST && k < 100) begin @(negedge ADC_PIXCLK); k++; end
    while (!bus.FSMIND1 && n < 500) begin n++; @(negedge ADC_PIXCLK); end
    n_vec++;
    if (n != want_len) begin
      n_miss++; $display("FAIL multi_len: GRST-to-FSMIND1 got %0d, want %0d", n, want_len);
    end
    wait_idle("multi");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev(EV_NONE, 0);
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL multi_evt: got kind=%0d val=%0d, want kind=%0d val=%0d",
                 o.kind, o.val, e.kind, e.val);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_miss++; $display("FAIL multi_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_continuous_stop();
    ev_t e, o;
    int g = 0, k = 0;
    logic prev = 1'b0;
    ack_dly = 1;
    set_cfg(1, 1, 6, 1'b1);
    for (int f = 1; f <= 3; f++) push_frame(1, 6, 1, f);
    pulse_start();
    // START mid-frame 2 must be ignored; STOP in the first EXPOSE cycle of frame 3.
    while (k < 3000 && g < 3) begin
      @(negedge ADC_PIXCLK);
      k++;
      bus.START = 1'b0;
      if (prev && !bus.GRST) begin
        g++;
        if (g == 2) bus.START = 1'b1;
      end
      prev = bus.GRST;
    end
    n_vec++;
    if (bus.MOD_EN !== 1'b1) begin
      n_miss++; $display("FAIL cont_stop_at: MOD_EN got %b, want 1 (frame %0d)", bus.MOD_EN, g);
    end
    bus.STOP = 1'b1;
    @(negedge ADC_PIXCLK) bus.STOP = 1'b0;
    wait_idle("cont");
    repeat (40) @(negedge ADC_PIXCLK);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev(EV_NONE, 0);
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL cont_evt: got kind=%0d val=%0d, want kind=%0d val=%0d",
                 o.kind, o.val, e.kind, e.val);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_miss++; $display("FAIL cont_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
    n_vec++;
    if (bus.FRAME_CNT !== 16'd3) begin
      n_miss++; $display("FAIL cont_cnt: FRAME_CNT got %0d, want 3", bus.FRAME_CNT);
    end
  endtask

  task automatic test_zero_fixup();
    ev_t e, o;
    ack_dly = 0;
    set_cfg(0, 0, 0, 1'b0);
    push_frame(1, 1, 0, 1);
    pulse_start();
    wait_idle("zero");
    set_cfg(1, 12, 1, 1'b0);
    push_frame(8, 1, 0, 1);
    pulse_start();
    wait_idle("clamp");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev(EV_NONE, 0);
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL zero_evt: got kind=%0d val=%0d, want kind=%0d val=%0d",
                 o.kind, o.val, e.kind, e.val);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_miss++; $display("FAIL zero_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_exp_change();
    ev_t e, o;
    int k = 0;
    ack_dly = 3;
    set_cfg(2, 2, 3, 1'b0);
    push_frame(2, 3, 3, 1);
    push_frame(2, 7, 3, 2);
    pulse_start();
    while (!bus.GRST && k < 100) begin @(negedge ADC_PIXCLK); k++; end
    bus.EXP_CYC = 16'd7;
    wait_idle("expchg");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev(EV_NONE, 0);
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL expchg_evt: got kind=%0d val=%0d, want kind=%0d val=%0d",
                 o.kind, o.val, e.kind, e.val);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_miss++; $display("FAIL expchg_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
    n_vec++;
    if (bus.FRAME_CNT !== 16'd2) begin
      n_miss++; $display("FAIL expchg_cnt: FRAME_CNT got %0d, want 2", bus.FRAME_CNT);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    ack_dly = 0;
    set_cfg(2, 1, 2, 1'b0);
    pulse_start();
    while (!bus.FRAME_DONE && k < 500) begin @(negedge ADC_PIXCLK); k++; end
    ack_en = 1'b0;
    while (!bus.FSMIND1 && k < 1000) begin @(negedge ADC_PIXCLK); k++; end
    n_vec++;
    if ({bus.FSMIND1, bus.FRAME_CNT} !== {1'b1, 16'd1}) begin
      n_miss++;
      $display("FAIL rstmid_pre: FSMIND1=%b FRAME_CNT=%0d, want 1 and 1", bus.FSMIND1, bus.FRAME_CNT);
    end
`ifndef SEQ_ACK_TIMEOUT_EN
    repeat (50) @(negedge ADC_PIXCLK);
    n_vec++;
    if ({bus.FSMIND1, bus.ERR} !== 2'b10) begin
      n_miss++; $display("FAIL hold_f1: {FSMIND1,ERR} got %b, want 10", {bus.FSMIND1, bus.ERR});
    end
`endif
    #1 RESETN = 1'b0;
    #1;
    n_vec++;
    if ({bus.FSMIND1, bus.BUSY, bus.MOD_EN, bus.GRST, bus.FRAME_CNT} !== 20'd0) begin
      n_miss++;
      $display("FAIL rstmid_async: FSMIND1=%b BUSY=%b FRAME_CNT=%0d, want all 0",
               bus.FSMIND1, bus.BUSY, bus.FRAME_CNT);
    end
    @(negedge ADC_PIXCLK) RESETN = 1'b1;
    ack_en = 1'b1;
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(negedge ADC_PIXCLK);
  endtask

`ifdef SEQ_ACK_TIMEOUT_EN
  task automatic test_timeout();
    ev_t e, o;
    ack_en = 1'b0;
    set_cfg(1, 1, 3, 1'b0);
    push_frame(1, 3, 19, 0);
    pulse_start();
    wait_idle("tmo");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : ev(EV_NONE, 0);
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL tmo_evt: got kind=%0d val=%0d, want kind=%0d val=%0d",
                 o.kind, o.val, e.kind, e.val);
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_miss++; $display("FAIL tmo_extra: got %0d extra events, want 0", obs_q.size());
      obs_q.delete();
    end
    n_vec++;
    if ({bus.ERR, bus.FRAME_CNT} !== {1'b1, 16'd0}) begin
      n_miss++; $display("FAIL tmo_err: ERR=%b FRAME_CNT=%0d, want 1 and 0", bus.ERR, bus.FRAME_CNT);
    end
    ack_en = 1'b1;
    pulse_start();
    n_vec++;
    if (bus.ERR !== 1'b0) begin
      n_miss++; $display("FAIL tmo_clear: ERR got %b after START, want 0", bus.ERR);
    end
    wait_idle("tmo2");
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_multi_sub();
    test_continuous_stop();
    test_zero_fixup();
    test_exp_change();
    test_reset_mid();
`ifdef SEQ_ACK_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
